// File: rtl/twd_trans_merger.sv
// twd_trans_merger
//   Completion-side partner of the 2D transfer splitter. Every accepted command
//   is queued as {sid, total bytes}. The 1D sub-transfer completions coming back
//   are accumulated against the head command. Once the accumulated byte count
//   reaches the head total, the head is retired and a one-cycle done pulse is
//   emitted carrying that command's SID.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_req_i             command offered; pushed when cmd_gnt_o is high
//   cmd_gnt_o             queue not full
//   cmd_sid_i, cmd_len_i  command SID and length (bytes-1)
//   beat_valid_i          one 1D sub-transfer completed
//   beat_sid_i/len_i      SID and length (bytes-1) of that sub-transfer
//   trans_done_o          registered pulse, head command complete
//   trans_done_sid_o      SID of the last completed command (held)
//   err_o                 sticky protocol error (orphan, SID mismatch, overshoot)
//   busy_o                at least one command outstanding
//   cmd_cnt_o             number of outstanding commands
//
// FSM states
//   state  | meaning
//   S_IDLE | queue empty, beats are orphans
//   S_RUN  | at least one command queued, beats accumulate against head
module twd_trans_merger #(
    parameter int TRANS_SID_WIDTH = 1,
    parameter int MCHAN_LEN_WIDTH = 16,
    parameter int CMD_QUEUE_DEPTH = 4,
    parameter int ACC_WIDTH       = MCHAN_LEN_WIDTH + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_req_i,
    output logic                           cmd_gnt_o,
    input  logic [TRANS_SID_WIDTH-1:0]     cmd_sid_i,
    input  logic [MCHAN_LEN_WIDTH-1:0]     cmd_len_i,
    input  logic                           beat_valid_i,
    input  logic [TRANS_SID_WIDTH-1:0]     beat_sid_i,
    input  logic [MCHAN_LEN_WIDTH-1:0]     beat_len_i,
    output logic                           trans_done_o,
    output logic [TRANS_SID_WIDTH-1:0]     trans_done_sid_o,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [$clog2(CMD_QUEUE_DEPTH):0] cmd_cnt_o
);
    localparam int PW = $clog2(CMD_QUEUE_DEPTH);
    localparam int NW = ACC_WIDTH + 1;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e                     state_q, state_d;
    logic [TRANS_SID_WIDTH-1:0] sid_mem_q [CMD_QUEUE_DEPTH];
    logic [ACC_WIDTH-1:0]       tot_mem_q [CMD_QUEUE_DEPTH];
    logic [PW:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic                       done_q, done_d;
    logic [TRANS_SID_WIDTH-1:0] done_sid_q, done_sid_d;
    logic                       err_q, err_d;

    logic                       full, push, pop;
    logic [PW:0]                cnt;
    logic [NW-1:0]              nxt, head_tot;
    logic [TRANS_SID_WIDTH-1:0] head_sid;
    logic [ACC_WIDTH-1:0]       new_tot;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign cnt      = wr_ptr_q - rd_ptr_q;
    assign head_sid = sid_mem_q[rd_ptr_q[PW-1:0]];
    assign head_tot = NW'(tot_mem_q[rd_ptr_q[PW-1:0]]);
    // Widened so that the largest beat on top of a nearly full accumulator cannot wrap.
    assign nxt      = NW'(acc_q) + NW'(beat_len_i) + NW'(1);
    assign new_tot  = ACC_WIDTH'(cmd_len_i) + ACC_WIDTH'(1);
    assign push     = cmd_req_i && !full;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (push) state_d = S_RUN;
            S_RUN:  if (pop && !push && cnt == (PW+1)'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        pop        = 1'b0;
        acc_d      = acc_q;
        err_d      = err_q;
        done_d     = 1'b0;
        done_sid_d = done_sid_q;
        wr_ptr_d   = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (beat_valid_i) begin
            if (state_q == S_IDLE) begin
                err_d = 1'b1;
            end else begin
                if (beat_sid_i != head_sid) err_d = 1'b1;
                if (nxt >= head_tot) begin
                    pop        = 1'b1;
                    acc_d      = '0;
                    done_d     = 1'b1;
                    done_sid_d = head_sid;
                    rd_ptr_d   = rd_ptr_q + (PW+1)'(1);
                    if (nxt > head_tot) err_d = 1'b1;
                end else begin
                    acc_d = nxt[ACC_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            acc_q      <= '0;
            done_q     <= 1'b0;
            done_sid_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < CMD_QUEUE_DEPTH; i++) begin
                sid_mem_q[i] <= '0;
                tot_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
            done_sid_q <= done_sid_d;
            err_q      <= err_d;
            if (push) begin
                sid_mem_q[wr_ptr_q[PW-1:0]] <= cmd_sid_i;
                tot_mem_q[wr_ptr_q[PW-1:0]] <= new_tot;
            end
        end
    end

    assign cmd_gnt_o        = !full;
    assign trans_done_o     = done_q;
    assign trans_done_sid_o = done_sid_q;
    assign err_o            = err_q;
    assign busy_o           = (state_q == S_RUN);
    assign cmd_cnt_o        = cnt;

endmodule

// File: tb/tb_twd_trans_merger.sv
module tb_twd_trans_merger;
    localparam int D = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_req_i = 1'b0;
    logic        cmd_gnt_o;
    logic [0:0]  cmd_sid_i = '0;
    logic [15:0] cmd_len_i = '0;
    logic        beat_valid_i = 1'b0;
    logic [0:0]  beat_sid_i = '0;
    logic [15:0] beat_len_i = '0;
    logic        trans_done_o;
    logic [0:0]  trans_done_sid_o;
    logic        err_o;
    logic        busy_o;
    logic [2:0]  cmd_cnt_o;

    int total = 0;
    int bad = 0;

    // Reference model: queue of commands and a byte accumulator.
    int   m_sid[$];
    int   m_tot[$];
    int   m_acc;
    logic m_err;
    logic m_done;
    logic [0:0] m_done_sid;

    twd_trans_merger dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_req_i(cmd_req_i), .cmd_gnt_o(cmd_gnt_o),
        .cmd_sid_i(cmd_sid_i), .cmd_len_i(cmd_len_i),
        .beat_valid_i(beat_valid_i), .beat_sid_i(beat_sid_i), .beat_len_i(beat_len_i),
        .trans_done_o(trans_done_o), .trans_done_sid_o(trans_done_sid_o),
        .err_o(err_o), .busy_o(busy_o), .cmd_cnt_o(cmd_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_clear();
        m_sid.delete();
        m_tot.delete();
        m_acc = 0;
        m_err = 1'b0;
        m_done = 1'b0;
        m_done_sid = '0;
    endtask

    // Drive one cycle of stimulus, advance the model, return at posedge+1.
    task automatic step(input bit req, input int sid, input int len,
                        input bit bv, input int bsid, input int blen);
        bit was_run = (m_tot.size() > 0);
        bit push    = req && (m_tot.size() < D);
        m_done = 1'b0;
        if (bv) begin
            if (!was_run) m_err = 1'b1;
            else begin
                if (bsid != m_sid[0]) m_err = 1'b1;
                if (m_acc + blen + 1 >= m_tot[0]) begin
                    if (m_acc + blen + 1 > m_tot[0]) m_err = 1'b1;
                    m_done = 1'b1;
                    m_done_sid = 1'(m_sid[0]);
                    void'(m_sid.pop_front());
                    void'(m_tot.pop_front());
                    m_acc = 0;
                end else m_acc = m_acc + blen + 1;
            end
        end
        if (push) begin
            m_sid.push_back(sid);
            m_tot.push_back(len + 1);
        end
        cmd_req_i    = req;
        cmd_sid_i    = 1'(sid);
        cmd_len_i    = 16'(len);
        beat_valid_i = bv;
        beat_sid_i   = 1'(bsid);
        beat_len_i   = 16'(blen);
        @(posedge clk_i);
        #1;
        cmd_req_i    = 1'b0;
        beat_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (trans_done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", trans_done_o); end
        total++; if (trans_done_sid_o !== 1'b0) begin bad++; $display("FAIL reset_sid got=%0d exp=0", trans_done_sid_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        total++; if (cmd_cnt_o !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cmd_cnt_o); end
        total++; if (cmd_gnt_o !== 1'b1) begin bad++; $display("FAIL reset_gnt got=%0b exp=1", cmd_gnt_o); end
    endtask

    task automatic test_1d();
        step(1, 1, 63, 0, 0, 0);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL 1d_busy got=%0b exp=1", busy_o); end
        step(0, 0, 0, 1, 1, 63);
        total++; if (trans_done_o !== 1'b1) begin bad++; $display("FAIL 1d_done got=%0b exp=1", trans_done_o); end
        total++; if (trans_done_sid_o !== 1'b1) begin bad++; $display("FAIL 1d_sid got=%0d exp=1", trans_done_sid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL 1d_busy_end got=%0b exp=0", busy_o); end
        step(0, 0, 0, 0, 0, 0);
        total++; if (trans_done_o !== 1'b0) begin bad++; $display("FAIL 1d_pulse_width got=%0b exp=0", trans_done_o); end
        total++; if (trans_done_sid_o !== 1'b1) begin bad++; $display("FAIL 1d_sid_hold got=%0d exp=1", trans_done_sid_o); end
    endtask

    task automatic test_2d();
        step(1, 0, 255, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0, 63);
            total++;
            if (trans_done_o !== (i == 3)) begin
                bad++; $display("FAIL 2d_beat%0d_done got=%0b exp=%0b", i, trans_done_o, (i == 3));
            end
        end
        total++; if (trans_done_sid_o !== 1'b0) begin bad++; $display("FAIL 2d_sid got=%0d exp=0", trans_done_sid_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL 2d_err got=%0b exp=0", err_o); end
    endtask

    task automatic test_full();
        for (int i = 0; i < D; i++) step(1, i % 2, 4 * i + 3, 0, 0, 0);
        total++; if (cmd_gnt_o !== 1'b0) begin bad++; $display("FAIL full_gnt got=%0b exp=0", cmd_gnt_o); end
        total++; if (cmd_cnt_o !== 3'd4) begin bad++; $display("FAIL full_cnt got=%0d exp=4", cmd_cnt_o); end
        step(1, 1, 99, 0, 0, 0);
        total++; if (cmd_cnt_o !== 3'd4) begin bad++; $display("FAIL full_ignore_cnt got=%0d exp=4", cmd_cnt_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL full_ignore_err got=%0b exp=0", err_o); end
        step(0, 0, 0, 1, 0, 3);
        total++; if (cmd_gnt_o !== 1'b1) begin bad++; $display("FAIL full_pop_gnt got=%0b exp=1", cmd_gnt_o); end
        total++; if (cmd_cnt_o !== 3'd3) begin bad++; $display("FAIL full_pop_cnt got=%0d exp=3", cmd_cnt_o); end
        // Push and pop together: count stays at 3.
        step(1, 0, 5, 1, 1, 7);
        total++; if (cmd_cnt_o !== 3'd3) begin bad++; $display("FAIL pushpop_cnt got=%0d exp=3", cmd_cnt_o); end
        total++; if (trans_done_o !== 1'b1 || trans_done_sid_o !== 1'b1) begin
            bad++; $display("FAIL pushpop_done got=%0b/%0d exp=1/1", trans_done_o, trans_done_sid_o);
        end
        // Back-to-back completions drain the remaining entries (totals 12, 16, 6).
        step(0, 0, 0, 1, 0, 11);
        step(0, 0, 0, 1, 1, 15);
        total++; if (trans_done_o !== 1'b1 || trans_done_sid_o !== 1'b1) begin
            bad++; $display("FAIL b2b_done got=%0b/%0d exp=1/1", trans_done_o, trans_done_sid_o);
        end
        step(0, 0, 0, 1, 0, 5);
        total++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("FAIL drain got busy=%0b err=%0b exp=0/0", busy_o, err_o);
        end
    endtask

    task automatic test_overshoot();
        step(1, 1, 15, 0, 0, 0);
        step(0, 0, 0, 1, 1, 31);
        total++; if (trans_done_o !== 1'b1) begin bad++; $display("FAIL over_done got=%0b exp=1", trans_done_o); end
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL over_err got=%0b exp=1", err_o); end
        total++; if (cmd_cnt_o !== 3'd0) begin bad++; $display("FAIL over_cnt got=%0d exp=0", cmd_cnt_o); end
    endtask

    task automatic test_orphan();
        do_reset();
        step(0, 0, 0, 1, 0, 7);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL orphan_err got=%0b exp=1", err_o); end
        total++; if (trans_done_o !== 1'b0) begin bad++; $display("FAIL orphan_done got=%0b exp=0", trans_done_o); end
        do_reset();
        // Beat alongside the first push is still an orphan; the command is queued.
        step(1, 0, 0, 1, 0, 0);
        total++; if (err_o !== 1'b1 || trans_done_o !== 1'b0 || cmd_cnt_o !== 3'd1) begin
            bad++; $display("FAIL orphan_push got err=%0b done=%0b cnt=%0d exp=1/0/1", err_o, trans_done_o, cmd_cnt_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1, 1, 255, 0, 0, 0);
        step(0, 0, 0, 1, 1, 63);
        step(0, 0, 0, 1, 1, 63);
        #2 rst_i = 1'b1;
        #1;
        total++; if (cmd_cnt_o !== 3'd0 || busy_o !== 1'b0 || cmd_gnt_o !== 1'b1) begin
            bad++; $display("FAIL midrst got cnt=%0d busy=%0b gnt=%0b exp=0/0/1", cmd_cnt_o, busy_o, cmd_gnt_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_clear();
        step(1, 0, 7, 0, 0, 0);
        step(0, 0, 0, 1, 0, 7);
        total++; if (trans_done_o !== 1'b1 || err_o !== 1'b0) begin
            bad++; $display("FAIL midrst_fresh got done=%0b err=%0b exp=1/0", trans_done_o, err_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit req = ($urandom % 3) == 0;
            int sid = int'($urandom % 2);
            int len = int'($urandom_range(0, 63));
            bit bv  = ($urandom % 2) == 1;
            int bsid = (m_sid.size() > 0 && ($urandom % 8) != 0) ? m_sid[0] : int'($urandom % 2);
            int blen = int'($urandom_range(0, 40));
            step(req, sid, len, bv, bsid, blen);
            total++;
            if (trans_done_o !== m_done || trans_done_sid_o !== m_done_sid || err_o !== m_err ||
                busy_o !== (m_tot.size() > 0) || cmd_cnt_o !== 3'(m_tot.size()) ||
                cmd_gnt_o !== (m_tot.size() < D)) begin
                bad++;
                $display("FAIL rand_c%0d got done=%0b sid=%0d err=%0b busy=%0b cnt=%0d gnt=%0b exp done=%0b sid=%0d err=%0b cnt=%0d",
                         c, trans_done_o, trans_done_sid_o, err_o, busy_o, cmd_cnt_o, cmd_gnt_o,
                         m_done, m_done_sid, m_err, m_tot.size());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_1d();
        test_2d();
        test_full();
        test_overshoot();
        test_orphan();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
